// File: rtl/icache_linefill_ctrl_if.sv
// Refill-path bundle between the downstream data channel, the MSHR entry
// array, the data RAM write port and the line-fill controller.
interface icache_linefill_ctrl_if #(
  parameter int ENTRY_IDX_W = 3,
  parameter int BEAT_W      = 128,
  parameter int BEATS       = 4,
  parameter int INDEX_W     = 7,
  parameter int WAY_W       = 1
);
  // Handshakes: a beat / line write transfers on a cycle where valid and ready
  // are both high at the clock edge; valid never drops before it transfers and
  // its payload is held stable until then.
  logic                     rxdat_vld;
  logic                     rxdat_rdy;
  logic [ENTRY_IDX_W-1:0]   rxdat_entry_id;
  logic [BEAT_W-1:0]        rxdat_data;
  logic                     rxdat_last;
  logic                     rxdat_err;
  logic [ENTRY_IDX_W-1:0]   lookup_entry_id;
  logic [INDEX_W-1:0]       lookup_index;
  logic [WAY_W-1:0]         lookup_way;
  logic                     ram_wr_vld;
  logic                     ram_wr_rdy;
  logic [INDEX_W-1:0]       ram_wr_index;
  logic [WAY_W-1:0]         ram_wr_way;
  logic [BEAT_W*BEATS-1:0]  ram_wr_data;
  logic                     linefill_done;
  logic [ENTRY_IDX_W:0]     linefill_ack_entry_idx;
  logic                     linefill_err;

  modport slave (
    input  rxdat_vld, rxdat_entry_id, rxdat_data, rxdat_last, rxdat_err,
    input  lookup_index, lookup_way, ram_wr_rdy,
    output rxdat_rdy, lookup_entry_id, ram_wr_vld, ram_wr_index, ram_wr_way,
    output ram_wr_data, linefill_done, linefill_ack_entry_idx, linefill_err
  );

  modport master (
    output rxdat_vld, rxdat_entry_id, rxdat_data, rxdat_last, rxdat_err,
    output lookup_index, lookup_way, ram_wr_rdy,
    input  rxdat_rdy, lookup_entry_id, ram_wr_vld, ram_wr_index, ram_wr_way,
    input  ram_wr_data, linefill_done, linefill_ack_entry_idx, linefill_err
  );
endinterface

// File: rtl/icache_linefill_ctrl.sv
// Collects the beats of one refill line, writes the assembled line to the
// data RAM and pulses linefill_done with the owning MSHR entry.
module icache_linefill_ctrl #(
  parameter int ENTRY_IDX_W = 3,
  parameter int BEAT_W      = 128,
  parameter int BEATS       = 4,
  parameter int INDEX_W     = 7,
  parameter int WAY_W       = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  icache_linefill_ctrl_if.slave lf,
  output logic [1:0]            o_dbg_state
);
  localparam int LINE_W = BEAT_W * BEATS;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_WRITE   = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]             r_state;
  logic [1:0]             w_state_nxt;
  logic                   r_rdy;
  logic [CNT_W-1:0]       r_beat_cnt;
  logic                   r_err;
  logic [ENTRY_IDX_W-1:0] r_id;
  logic [LINE_W-1:0]      r_line;
  logic [INDEX_W-1:0]     r_wr_index;
  logic [WAY_W-1:0]       r_wr_way;

  logic             w_acc;
  logic [CNT_W-1:0] w_k;
  logic             w_last_beat;
  logic             w_beat_err;
  logic             w_err_acc;

  assign w_acc = lf.rxdat_vld & r_rdy;
  assign w_k   = (r_state == S_IDLE) ? '0 : r_beat_cnt;

  always_comb begin
    w_last_beat = 1'b0;
    w_beat_err  = 1'b0;
    w_err_acc   = 1'b0;
    if (r_state == S_IDLE) begin
      w_last_beat = (BEATS == 1);
      w_beat_err  = lf.rxdat_err;
      w_err_acc   = w_beat_err;
    end else if (r_state == S_COLLECT) begin
      w_last_beat = (r_beat_cnt == CNT_W'(BEATS - 1));
      // rxdat_last must coincide exactly with the final beat: early or missing both fault
      w_beat_err  = lf.rxdat_err | (lf.rxdat_entry_id != r_id) |
                    (lf.rxdat_last != w_last_beat);
      w_err_acc   = r_err | w_beat_err;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_COLLECT: begin
        if (w_acc) begin
          if (w_last_beat) w_state_nxt = w_err_acc ? S_DONE : S_WRITE;
          else             w_state_nxt = S_COLLECT;
        end
      end
      S_WRITE: if (lf.ram_wr_rdy) w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_rdy      <= 1'b0;
      r_beat_cnt <= '0;
      r_err      <= 1'b0;
      r_id       <= '0;
      r_line     <= '0;
      r_wr_index <= '0;
      r_wr_way   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rdy   <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_COLLECT);
      if (w_acc) begin
        if (r_state == S_IDLE) r_id <= lf.rxdat_entry_id;
        for (int b = 0; b < BEATS; b++) begin
          if (w_k == CNT_W'(b)) r_line[b*BEAT_W +: BEAT_W] <= lf.rxdat_data;
        end
        r_err      <= w_err_acc;
        r_beat_cnt <= w_last_beat ? '0 : (w_k + CNT_W'(1));
      end
      // MSHR holds index/way stable for the active entry, so one sample suffices
      if ((w_state_nxt == S_WRITE) && (r_state != S_WRITE)) begin
        r_wr_index <= lf.lookup_index;
        r_wr_way   <= lf.lookup_way;
      end
      if (r_state == S_DONE) r_err <= 1'b0;
    end
  end

  assign lf.rxdat_rdy              = r_rdy;
  assign lf.lookup_entry_id        = r_id;
  assign lf.ram_wr_vld             = (r_state == S_WRITE);
  assign lf.ram_wr_index           = r_wr_index;
  assign lf.ram_wr_way             = r_wr_way;
  assign lf.ram_wr_data            = r_line;
  assign lf.linefill_done          = (r_state == S_DONE);
  assign lf.linefill_ack_entry_idx = (r_state == S_DONE) ? {1'b0, r_id} : '0;
  assign lf.linefill_err           = (r_state == S_DONE) & r_err;
  assign o_dbg_state               = r_state;
endmodule

// File: tb/tb_icache_linefill_ctrl.sv
// Directed bench for icache_linefill_ctrl: line-level model with expected
// write/done queues, a per-cycle compare process and literal spot checks.
module tb_icache_linefill_ctrl;
  localparam int LINE_W = 512;
  localparam int WR_W   = LINE_W + 7 + 1;

  logic clk;
  logic rst_n;
  logic [1:0] dbg_state;
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  icache_linefill_ctrl_if bus ();

  icache_linefill_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .lf          (bus.slave),
    .o_dbg_state (dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard queues: {data, index, way} per line write, {ack_idx, err} per done
  logic [WR_W-1:0] exp_wr_q[$];
  logic [4:0]      exp_done_q[$];
  logic [3:0]      done_hist[$];

  int wr_first_cyc = 0;
  int done_cyc = 0;
  int vld_cnt = 0;
  int wr_hs = 0;
  logic [WR_W-1:0] last_wr = '0;
  logic [3:0] last_ack = '0;
  logic last_err = 1'b0;
  logic prev_vld = 1'b0;

  task automatic chk(input string nm, input logic [WR_W-1:0] act, input logic [WR_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [127:0] beat(input logic [3:0] x);
    return {32{x}};
  endfunction

  // Line-level rules: any beat error, txnid change, or last not exactly on beat 3
  function automatic logic line_err(input logic [3:0][2:0] ids, input logic [3:0] lasts,
                                    input logic [3:0] errs);
    logic e;
    e = |errs;
    for (int k = 1; k < 4; k++) if (ids[k] != ids[0]) e = 1'b1;
    if (lasts != 4'b1000) e = 1'b1;
    return e;
  endfunction

  // Compare process: every cycle a write or done is visible
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prev_vld = 1'b0;
    end else begin
      if (bus.ram_wr_vld) begin
        if (!prev_vld) begin
          wr_first_cyc = cyc;
          vld_cnt = 0;
        end
        vld_cnt++;
        chk("rxdat_rdy_during_write", bus.rxdat_rdy, 0);
        if (exp_wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got index %0h way %0h, required none", bus.ram_wr_index, bus.ram_wr_way);
        end else begin
          chk("ram_wr_payload", {bus.ram_wr_data, bus.ram_wr_index, bus.ram_wr_way}, exp_wr_q[0]);
          if (bus.ram_wr_rdy) begin
            last_wr = exp_wr_q.pop_front();
            wr_hs++;
          end
        end
      end
      prev_vld = bus.ram_wr_vld;
      if (bus.linefill_done) begin
        done_cyc = cyc;
        chk("rxdat_rdy_during_done", bus.rxdat_rdy, 0);
        if (exp_done_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got ack %0h, required none", bus.linefill_ack_entry_idx);
        end else begin
          chk("done_ack_err", {bus.linefill_ack_entry_idx, bus.linefill_err}, exp_done_q.pop_front());
        end
        last_ack = bus.linefill_ack_entry_idx;
        last_err = bus.linefill_err;
        done_hist.push_back(bus.linefill_ack_entry_idx);
      end
    end
  end

  task automatic send_beat(input logic [2:0] id, input logic [127:0] data, input logic last,
                           input logic err, output int acc_cyc);
    int n;
    bus.rxdat_vld      = 1'b1;
    bus.rxdat_entry_id = id;
    bus.rxdat_data     = data;
    bus.rxdat_last     = last;
    bus.rxdat_err      = err;
    n = 0;
    @(negedge clk);
    while (!bus.rxdat_rdy && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!bus.rxdat_rdy) begin
      checks++;
      errors++;
      $display("FAIL beat_accept_timeout: rxdat_rdy got 0 required 1 within 50 cycles");
    end
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    bus.rxdat_vld = 1'b0;
  endtask

  task automatic send_line(input logic [3:0][2:0] ids, input logic [3:0][127:0] data,
                           input logic [3:0] lasts, input logic [3:0] errs,
                           input logic [6:0] idx, input logic way,
                           output int first_c, output int last_c);
    int c;
    logic e;
    e = line_err(ids, lasts, errs);
    if (!e) exp_wr_q.push_back({data, idx, way});
    exp_done_q.push_back({1'b0, ids[0], e});
    bus.lookup_index = idx;
    bus.lookup_way   = way;
    first_c = 0;
    for (int k = 0; k < 4; k++) begin
      send_beat(ids[k], data[k], lasts[k], errs[k], c);
      if (k == 0) first_c = c;
    end
    last_c = c;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_wr_q.size() != 0 || exp_done_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", exp_wr_q.size() + exp_done_q.size(), 0);
  endtask

  logic [3:0][127:0] d1234;
  int f1, l1, f2, l2, hs0;

  initial begin
    rst_n = 1'b0;
    bus.rxdat_vld = 1'b0;
    bus.rxdat_entry_id = '0;
    bus.rxdat_data = '0;
    bus.rxdat_last = 1'b0;
    bus.rxdat_err = 1'b0;
    bus.lookup_index = '0;
    bus.lookup_way = '0;
    bus.ram_wr_rdy = 1'b1;
    d1234 = {beat(4'h4), beat(4'h3), beat(4'h2), beat(4'h1)};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_rdy", bus.rxdat_rdy, 0);
    chk("reset_outputs", {bus.ram_wr_vld, bus.linefill_done, bus.linefill_ack_entry_idx,
        bus.linefill_err, bus.ram_wr_index, bus.ram_wr_way, bus.lookup_entry_id}, 0);
    chk("reset_line", bus.ram_wr_data, 0);
    rst_n = 1'b1;
    #1 chk("rdy_at_deassert", bus.rxdat_rdy, 0);
    @(negedge clk);
    chk("rdy_after_reset", bus.rxdat_rdy, 1);

    // Clean fill
    @(posedge clk); #1;
    send_line({3'd5, 3'd5, 3'd5, 3'd5}, d1234, 4'b1000, 4'b0000, 7'h2A, 1'b1, f1, l1);
    wait_idle();
    chk("clean_vld_latency", wr_first_cyc, l1 + 1);
    chk("clean_done_latency", done_cyc, l1 + 2);
    chk("clean_data_literal", last_wr[WR_W-1:8], {beat(4'h4), beat(4'h3), beat(4'h2), beat(4'h1)});
    chk("clean_index_way", last_wr[7:0], {7'h2A, 1'b1});
    chk("clean_ack_literal", {last_ack, last_err}, {4'b0101, 1'b0});
    chk("lookup_entry_id", bus.lookup_entry_id, 5);

    // Write backpressure: rdy low for the first 3 write cycles
    @(posedge clk); #1;
    bus.ram_wr_rdy = 1'b0;
    send_line({3'd3, 3'd3, 3'd3, 3'd3}, {beat(4'h8), beat(4'h7), beat(4'h6), beat(4'h5)},
              4'b1000, 4'b0000, 7'h11, 1'b0, f1, l1);
    repeat (3) @(posedge clk);
    #1 bus.ram_wr_rdy = 1'b1;
    wait_idle();
    chk("bp_vld_cycles", vld_cnt, 4);
    chk("bp_done_latency", done_cyc, l1 + 5);

    // Error beat
    @(posedge clk); #1;
    hs0 = wr_hs;
    send_line({3'd2, 3'd2, 3'd2, 3'd2}, d1234, 4'b1000, 4'b0010, 7'h05, 1'b0, f1, l1);
    wait_idle();
    chk("errbeat_done_latency", done_cyc, l1 + 1);
    chk("errbeat_ack_literal", {last_ack, last_err}, {4'd2, 1'b1});
    chk("errbeat_no_write", wr_hs, hs0);

    // Entry id changes on beat 2
    @(posedge clk); #1;
    send_line({3'd6, 3'd6, 3'd3, 3'd3}, d1234, 4'b1000, 4'b0000, 7'h06, 1'b1, f1, l1);
    wait_idle();
    chk("idchg_done_latency", done_cyc, l1 + 1);

    // Early last on beat 1: still consumes all 4 beats
    @(posedge clk); #1;
    send_line({3'd4, 3'd4, 3'd4, 3'd4}, d1234, 4'b1010, 4'b0000, 7'h07, 1'b0, f1, l1);
    wait_idle();
    chk("earlylast_done_latency", done_cyc, l1 + 1);

    // Missing last on the final beat
    @(posedge clk); #1;
    send_line({3'd1, 3'd1, 3'd1, 3'd1}, d1234, 4'b0000, 4'b0000, 7'h08, 1'b0, f1, l1);
    wait_idle();
    chk("nolast_done_latency", done_cyc, l1 + 1);
    chk("faults_no_write", wr_hs, hs0);

    // Back-to-back lines with continuous rxdat_vld
    @(posedge clk); #1;
    send_line({3'd0, 3'd0, 3'd0, 3'd0}, d1234, 4'b1000, 4'b0000, 7'h10, 1'b0, f1, l1);
    send_line({3'd7, 3'd7, 3'd7, 3'd7}, {beat(4'hD), beat(4'hC), beat(4'hB), beat(4'hA)},
              4'b1000, 4'b0000, 7'h70, 1'b1, f2, l2);
    wait_idle();
    chk("b2b_second_accept", f2, l1 + 3);
    chk("b2b_done_order", {done_hist[done_hist.size()-2], done_hist[done_hist.size()-1]}, {4'd0, 4'd7});

    // Reset after 2 beats discards the partial line
    @(posedge clk); #1;
    hs0 = wr_hs;
    send_beat(3'd1, beat(4'hE), 1'b0, 1'b0, f1);
    send_beat(3'd1, beat(4'hF), 1'b0, 1'b0, f1);
    #2 rst_n = 1'b0;
    #1 chk("midreset_outputs", {bus.rxdat_rdy, bus.ram_wr_vld, bus.linefill_done}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midreset_rdy_back", bus.rxdat_rdy, 1);
    @(posedge clk); #1;
    send_line({3'd6, 3'd6, 3'd6, 3'd6}, {beat(4'h9), beat(4'hA), beat(4'hB), beat(4'hC)},
              4'b1000, 4'b0000, 7'h55, 1'b0, f1, l1);
    wait_idle();
    chk("postreset_writes", wr_hs, hs0 + 1);
    chk("postreset_ack", {last_ack, last_err}, {4'd6, 1'b0});

    repeat (3) @(negedge clk);
    chk("final_queues_empty", exp_wr_q.size() + exp_done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/icache_linefill_ctrl.md
Name: icache_linefill_ctrl

Overview:
Sits between the downstream read-data channel and the icache MSHR file / data RAM write port. It collects the data beats of one refill line into a line buffer, writes the assembled line to the data RAM, and then pulses linefill_done with the owning MSHR entry index, which the MSHR file uses to release that entry. One line is in flight at a time. Beats of one line arrive contiguously and are never interleaved with beats of another line.

Parameters:
ENTRY_IDX_W, 3, MSHR entry index width (entries = 2^ENTRY_IDX_W).
BEAT_W, 128, data bits per downstream beat.
BEATS, 4, beats per cache line; LINE_W = BEAT_W*BEATS.
INDEX_W, 7, icache set index width.
WAY_W, 1, way select width (2 ways).

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
rxdat_vld  in  1  downstream data beat valid
rxdat_rdy  out  1  beat accepted when vld&rdy
rxdat_entry_id  in  ENTRY_IDX_W  MSHR entry owning the beat (txnid)
rxdat_data  in  BEAT_W  beat payload
rxdat_last  in  1  downstream marks final beat
rxdat_err  in  1  downstream error on this beat
lookup_entry_id  out  ENTRY_IDX_W  entry whose index/way is being read (latched id)
lookup_index  in  INDEX_W  set index of lookup_entry_id, from MSHR entry array
lookup_way  in  WAY_W  victim way of lookup_entry_id
ram_wr_vld  out  1  data RAM line-write request
ram_wr_rdy  in  1  data RAM accepts write
ram_wr_index  out  INDEX_W  write set index
ram_wr_way  out  WAY_W  write way
ram_wr_data  out  LINE_W  assembled line
linefill_done  out  1  one-cycle pulse: line finished
linefill_ack_entry_idx  out  ENTRY_IDX_W+1  {1'b0, entry id}, valid with linefill_done
linefill_err  out  1  valid with linefill_done; line was not written

Behaviour:
- Reset values: all outputs 0 except rxdat_rdy, which is 1 one cycle after reset deassertion. Internal state: FSM=IDLE, beat_cnt=0, err=0, line buffer=0.
- FSM states: IDLE, COLLECT, WRITE, DONE.
- IDLE: rxdat_rdy=1. On an accepted beat:
  - latch entry_id; store beat at data[0 +: BEAT_W]; err <= rxdat_err.
  - If BEATS==1, go to WRITE (or DONE if err); otherwise beat_cnt <= 1 and go to COLLECT.
- COLLECT: rxdat_rdy=1. Accepted beat k = beat_cnt is stored at data[k*BEAT_W +: BEAT_W].
  - err is sticky-set by: rxdat_err; rxdat_entry_id != latched id; rxdat_last=1 with k != BEATS-1.
  - Early rxdat_last does not end the line.
  - On k == BEATS-1: beat_cnt <= 0. A missing rxdat_last on that beat sets err.
  - Next state is WRITE, or DONE if err (including err set by the final beat).
- WRITE: rxdat_rdy=0.
  - On entry, register lookup_index/lookup_way into ram_wr_index/ram_wr_way.
  - ram_wr_vld=1; index, way and data are held stable until ram_wr_rdy.
  - When vld&rdy, go to DONE. ram_wr_vld never drops without a handshake.
- DONE: rxdat_rdy=0; linefill_done=1 for exactly one cycle; linefill_ack_entry_idx = {1'b0, id}; linefill_err = err. Next state IDLE; err cleared.
- Latency: final beat accepted in cycle N → ram_wr_vld at N+1. With rdy at N+1: done at N+2, rxdat_rdy=1 at N+3. An error line: done at N+1.
- lookup_entry_id always drives the latched id. The MSHR holds index/way stable while its entry is active.
- rxdat_vld while rxdat_rdy=0: ignored, no state change.
- Reset mid-line or mid-write: partial line discarded; no write, no done pulse.

Test Plan:
- Clean fill: 4 beats id=5, data 0x1..,0x2..,0x3..,0x4.., last on beat 3; lookup index=0x2A, way=1; ram_wr_rdy=1 → ram_wr_vld one cycle after beat 3 with data {b3,b2,b1,b0}, index 0x2A, way 1; linefill_done next cycle, ack_idx=4'b0101, err=0.
- Write backpressure: ram_wr_rdy low 3 cycles → ram_wr_vld held with stable payload 4 cycles; done one cycle after handshake; rxdat_rdy=0 throughout.
- Error beat: beat 1 rxdat_err=1, id=2 → no ram_wr_vld; done one cycle after beat 3 with ack_idx=2, err=1.
- Protocol faults: id changes 3→6 on beat 2 → err=1, no write. Separate line: rxdat_last on beat 1 → err=1, still consumes 4 beats.
- Back-to-back lines id=0 then id=7 with continuous rxdat_vld → second line's first beat accepted at N+3; two done pulses with ack_idx 0 then 7.
- Reset asserted after 2 beats → no done, no write; next clean line completes normally with only its own beats.
